fpu_stream_master: RTL and testbench

Initiator-side adapter for the team's 16-bit-word FPU cores (divider, multiplier, adder). Accepts one 32-bit operand pair per command on a valid/ready interface. Serialises each operand as high half then low half onto the core's `a`/`b` stb/ack ports, then collects the two 16-bit result halves. Presents the assembled 32-bit result, plus a latency count, on a valid/ready output. One operation is in flight at a time.

---
 rtl/fpu_stream_pkg.sv | 27 ++
 rtl/fpu_stream_master.sv | 181 ++++++++++++++++++
 tb/tb_fpu_stream_master.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_stream_pkg.sv
// Shared types and constants for the FPU stream master and its benches.
// Holds the FSM state encoding, default widths and canned IEEE-754 values.
package fpu_stream_pkg;

  localparam int unsigned WORD_DEFAULT  = 16;
  localparam int unsigned CNT_W_DEFAULT = 16;

  localparam logic [31:0] FP_QNAN = 32'hFFC0_0000;
  localparam logic [31:0] FP_PINF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    StIdle,
    StAHi,
    StALo,
    StBHi,
    StBLo,
    StZHi,
    StZLo,
    StHold
  } state_e;

  // Latency is counted only while an operation is actually talking to the core.
  function automatic logic state_counts(input state_e s);
    return (s != StIdle) && (s != StHold);
  endfunction

endpackage

// File: rtl/fpu_stream_master.sv
// Initiator adapter for the 16-bit-word FPU cores: serialises a 32-bit operand
// pair onto the core a/b ports, collects two z words, returns result and latency.
module fpu_stream_master
  import fpu_stream_pkg::*;
#(
  parameter int unsigned WORD  = WORD_DEFAULT,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2*WORD-1:0]  cmd_a,
  input  logic [2*WORD-1:0]  cmd_b,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  output logic [WORD-1:0]    core_a,
  output logic               core_a_stb,
  input  logic               core_a_ack,
  output logic [WORD-1:0]    core_b,
  output logic               core_b_stb,
  input  logic               core_b_ack,
  input  logic [WORD-1:0]    core_z,
  input  logic               core_z_stb,
  output logic               core_z_ack,
  output logic [2*WORD-1:0]  res_z,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CNT_W-1:0]   res_cycles
);

  state_e              state_q, state_d;
  logic [WORD-1:0]     a_lo_q, a_lo_d;
  logic [2*WORD-1:0]   b_q, b_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [WORD-1:0]     core_a_q, core_a_d;
  logic                core_a_stb_q, core_a_stb_d;
  logic [WORD-1:0]     core_b_q, core_b_d;
  logic                core_b_stb_q, core_b_stb_d;
  logic                core_z_ack_q, core_z_ack_d;
  logic [2*WORD-1:0]   res_z_q, res_z_d;
  logic                res_valid_q, res_valid_d;
  logic [CNT_W-1:0]    res_cycles_q, res_cycles_d;

  logic a_xfer, b_xfer, z_xfer, res_xfer, cmd_xfer, cnt_sat;

  assign cmd_xfer = cmd_valid && cmd_ready_q;
  assign a_xfer   = core_a_stb_q && core_a_ack;
  assign b_xfer   = core_b_stb_q && core_b_ack;
  assign z_xfer   = core_z_stb && core_z_ack_q;
  assign res_xfer = res_valid_q && res_ready;
  assign cnt_sat  = (cnt_q == {CNT_W{1'b1}});

  always_comb begin
    state_d      = state_q;
    a_lo_d       = a_lo_q;
    b_d          = b_q;
    cnt_d        = cnt_q;
    cmd_ready_d  = cmd_ready_q;
    core_a_d     = core_a_q;
    core_a_stb_d = core_a_stb_q;
    core_b_d     = core_b_q;
    core_b_stb_d = core_b_stb_q;
    core_z_ack_d = core_z_ack_q;
    res_z_d      = res_z_q;
    res_valid_d  = res_valid_q;
    res_cycles_d = res_cycles_q;

    if (state_counts(state_q) && !cnt_sat) begin
      cnt_d = cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        cmd_ready_d = 1'b1;
        if (cmd_xfer) begin
          a_lo_d       = cmd_a[WORD-1:0];
          b_d          = cmd_b;
          cmd_ready_d  = 1'b0;
          core_a_d     = cmd_a[2*WORD-1:WORD];
          core_a_stb_d = 1'b1;
          cnt_d        = '0;
          state_d      = StAHi;
        end
      end
      StAHi: begin
        if (a_xfer) begin
          core_a_d = a_lo_q;
          state_d  = StALo;
        end
      end
      StALo: begin
        if (a_xfer) begin
          core_a_stb_d = 1'b0;
          core_b_d     = b_q[2*WORD-1:WORD];
          core_b_stb_d = 1'b1;
          state_d      = StBHi;
        end
      end
      StBHi: begin
        if (b_xfer) begin
          core_b_d = b_q[WORD-1:0];
          state_d  = StBLo;
        end
      end
      StBLo: begin
        if (b_xfer) begin
          core_b_stb_d = 1'b0;
          core_z_ack_d = 1'b1;
          state_d      = StZHi;
        end
      end
      StZHi: begin
        if (z_xfer) begin
          res_z_d[2*WORD-1:WORD] = core_z;
          state_d                = StZLo;
        end
      end
      StZLo: begin
        if (z_xfer) begin
          res_z_d[WORD-1:0] = core_z;
          core_z_ack_d      = 1'b0;
          res_valid_d       = 1'b1;
          res_cycles_d      = cnt_sat ? cnt_q : cnt_q + 1'b1;
          state_d           = StHold;
        end
      end
      StHold: begin
        // cmd_ready rises with the result transfer so the next command can land one edge later.
        if (res_xfer) begin
          res_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      a_lo_q       <= '0;
      b_q          <= '0;
      cnt_q        <= '0;
      cmd_ready_q  <= 1'b0;
      core_a_q     <= '0;
      core_a_stb_q <= 1'b0;
      core_b_q     <= '0;
      core_b_stb_q <= 1'b0;
      core_z_ack_q <= 1'b0;
      res_z_q      <= '0;
      res_valid_q  <= 1'b0;
      res_cycles_q <= '0;
    end else begin
      state_q      <= state_d;
      a_lo_q       <= a_lo_d;
      b_q          <= b_d;
      cnt_q        <= cnt_d;
      cmd_ready_q  <= cmd_ready_d;
      core_a_q     <= core_a_d;
      core_a_stb_q <= core_a_stb_d;
      core_b_q     <= core_b_d;
      core_b_stb_q <= core_b_stb_d;
      core_z_ack_q <= core_z_ack_d;
      res_z_q      <= res_z_d;
      res_valid_q  <= res_valid_d;
      res_cycles_q <= res_cycles_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign core_a     = core_a_q;
  assign core_a_stb = core_a_stb_q;
  assign core_b     = core_b_q;
  assign core_b_stb = core_b_stb_q;
  assign core_z_ack = core_z_ack_q;
  assign res_z      = res_z_q;
  assign res_valid  = res_valid_q;
  assign res_cycles = res_cycles_q;

endmodule

// File: tb/tb_fpu_stream_master.sv
// Directed bench for fpu_stream_master against a behavioural divider core model
// with configurable A-ack stall and Z-return delay.
module tb_fpu_stream_master;
  import fpu_stream_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] core_a, core_b;
  logic        core_a_stb, core_b_stb;
  logic        core_a_ack = 1'b0, core_b_ack = 1'b0;
  logic [15:0] core_z = '0;
  logic        core_z_stb = 1'b0;
  logic        core_z_ack;
  logic [31:0] res_z;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_cycles;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fpu_stream_master #(.WORD(16), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .core_a     (core_a),
    .core_a_stb (core_a_stb),
    .core_a_ack (core_a_ack),
    .core_b     (core_b),
    .core_b_stb (core_b_stb),
    .core_b_ack (core_b_ack),
    .core_z     (core_z),
    .core_z_stb (core_z_stb),
    .core_z_ack (core_z_ack),
    .res_z      (res_z),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_cycles (res_cycles)
  );

  // Divider core model: records words seen on each port, answers from a small table.
  logic [15:0] a_w [0:1];
  logic [15:0] b_w [0:1];
  int a_n = 0, b_n = 0, z_n = 0;
  int cfg_a_stall = 0, cfg_z_delay = 0;
  int a_stall_cnt = 0, z_wait_cnt = 0;
  logic [31:0] model_z;

  function automatic logic [31:0] div_table(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h40C00000_40000000: return 32'h40400000;
      64'h3F800000_00000000: return FP_PINF;
      64'h40800000_40000000: return 32'h40000000;
      64'h40000000_40000000: return 32'h3F800000;
      default:               return FP_QNAN;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      a_n <= 0;
      b_n <= 0;
      z_n <= 0;
    end else begin
      if (core_a_stb && core_a_ack && a_n < 2) begin
        a_w[a_n[0]] <= core_a;
        a_n <= a_n + 1;
      end
      if (core_b_stb && core_b_ack && b_n < 2) begin
        b_w[b_n[0]] <= core_b;
        b_n <= b_n + 1;
      end
      if (core_z_stb && core_z_ack) begin
        if (z_n == 1) begin
          a_n <= 0;
          b_n <= 0;
          z_n <= 0;
        end else begin
          z_n <= z_n + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (core_a_stb && a_n == 0 && a_stall_cnt < cfg_a_stall) begin
      core_a_ack = 1'b0;
      a_stall_cnt++;
    end else begin
      core_a_ack = 1'b1;
      if (a_n != 0) a_stall_cnt = 0;
    end
    core_b_ack = 1'b1;
    model_z = div_table({a_w[0], a_w[1]}, {b_w[0], b_w[1]});
    if (b_n == 2) begin
      if (z_wait_cnt < cfg_z_delay) begin
        z_wait_cnt++;
        core_z_stb = 1'b0;
      end else begin
        core_z_stb = 1'b1;
        core_z = (z_n == 0) ? model_z[31:16] : model_z[15:0];
      end
    end else begin
      // Junk strobe while the master is not acking; it must be ignored.
      z_wait_cnt = 0;
      core_z_stb = 1'b1;
      core_z = 16'hDEAD;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns the cycle number of the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit keep,
                       output int acc);
    int n = 0;
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    acc = cyc + 1;
    if (!cmd_ready) chk("accept_timeout", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int seen);
    int n = 0;
    while (!res_valid && n < limit) begin
      @(negedge clk);
      n++;
    end
    seen = cyc;
    chk("res_valid_timeout", {31'b0, res_valid}, 32'd1);
  endtask

  task automatic take_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    int acc, acc2, seen, xfer, n;
    bit ok;
    logic [31:0] z0;
    logic [15:0] c0;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("rst_a_stb", {31'b0, core_a_stb}, 32'd0);
    chk("rst_b_stb", {31'b0, core_b_stb}, 32'd0);
    chk("rst_z_ack", {31'b0, core_z_ack}, 32'd0);
    chk("rst_res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst_core_a", {16'b0, core_a}, 32'd0);
    chk("rst_core_b", {16'b0, core_b}, 32'd0);
    chk("rst_res_z", res_z, 32'd0);
    chk("rst_res_cycles", {16'b0, res_cycles}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {31'b0, cmd_ready}, 32'd1);

    // 6.0 / 2.0, no stalls
    issue(32'h40C00000, 32'h40000000, 1'b0, acc);
    wait_valid(50, seen);
    chk("min_latency", seen - acc, 32'd6);
    chk("div_res_z", res_z, 32'h40400000);
    chk("div_res_cycles", {16'b0, res_cycles}, 32'd6);
    chk("valid_ready_excl", {31'b0, cmd_ready}, 32'd0);
    chk("a_words", {a_w[0], a_w[1]}, 32'h40C00000);
    chk("b_words", {b_w[0], b_w[1]}, 32'h40000000);
    take_result();
    chk("idle_after_take", {30'b0, res_valid, cmd_ready}, 32'd1);

    // A high word stalled for 5 cycles
    cfg_a_stall = 5;
    issue(32'h40C00000, 32'h40000000, 1'b0, acc);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!(core_a_stb === 1'b1 && core_a === 16'h40C0)) ok = 1'b0;
      @(negedge clk);
    end
    chk("a_stall_hold", {31'b0, ok}, 32'd1);
    wait_valid(50, seen);
    chk("stall_res_cycles", {16'b0, res_cycles}, 32'd11);
    chk("stall_res_z", res_z, 32'h40400000);
    take_result();
    cfg_a_stall = 0;

    // 1.0 / 0.0 with a 10-cycle downstream stall
    issue(32'h3F800000, 32'h00000000, 1'b0, acc);
    wait_valid(50, seen);
    z0 = res_z;
    c0 = res_cycles;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!(res_valid === 1'b1 && res_z === z0 && res_cycles === c0 && cmd_ready === 1'b0))
        ok = 1'b0;
    end
    chk("hold_stable", {31'b0, ok}, 32'd1);
    chk("inf_res_z", res_z, FP_PINF);
    chk("inf_res_cycles", {16'b0, res_cycles}, 32'd6);
    take_result();

    // Back-to-back with res_ready tied high and cmd_valid left asserted
    res_ready = 1'b1;
    issue(32'h40800000, 32'h40000000, 1'b1, acc);
    cmd_a = 32'h40C00000;
    cmd_b = 32'h40000000;
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    xfer = cyc + 1;
    chk("b2b_first_res_z", res_z, 32'h40000000);
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc2 = cyc + 1;
    chk("b2b_accept_gap", acc2 - xfer, 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_second_res_z", res_z, 32'h40400000);
    chk("b2b_second_cycles", {16'b0, res_cycles}, 32'd6);
    @(negedge clk);
    res_ready = 1'b0;
    chk("b2b_released", {31'b0, res_valid}, 32'd0);

    // Reset during B_LO, then a fresh command
    issue(32'h40C00000, 32'h40000000, 1'b0, acc);
    n = 0;
    while (b_n != 1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_b_lo", {31'b0, core_b_stb}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_strobes", {29'b0, core_a_stb, core_b_stb, core_z_ack}, 32'd0);
    chk("mid_rst_ready_valid", {30'b0, cmd_ready, res_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    issue(32'h3F800000, 32'h00000000, 1'b0, acc);
    wait_valid(50, seen);
    chk("post_rst_res_z", res_z, FP_PINF);
    chk("post_rst_cycles", {16'b0, res_cycles}, 32'd6);
    take_result();

    // Core withholds Z long enough to saturate the latency counter
    cfg_z_delay = 70000;
    issue(32'h40000000, 32'h40000000, 1'b0, acc);
    wait_valid(71000, seen);
    chk("sat_res_cycles", {16'b0, res_cycles}, 32'h0000FFFF);
    chk("sat_res_z", res_z, 32'h3F800000);
    take_result();
    cfg_z_delay = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
